// File: rtl/ibex_dmem_responder.sv
// rtl/ibex_dmem_responder.sv - data memory responder: req/gnt/rvalid, fixed latency, CHERIoT tag clearing
// Optional random grant stalls under macro DMEM_RESP_STALL_EN.
module ibex_dmem_responder #(
    parameter int unsigned DataWidth      = 33,
    parameter int unsigned MemDepthW      = 12,
    parameter logic [31:0] BaseAddr       = 32'h2000_0000,
    parameter int unsigned ReadLatency    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 data_req_i,
    input  logic                 data_is_cap_i,
    input  logic                 data_we_i,
    input  logic [3:0]           data_be_i,
    input  logic [31:0]          data_addr_i,
    input  logic [DataWidth-1:0] data_wdata_i,
    output logic                 data_gnt_o,
    output logic                 data_rvalid_o,
    output logic [DataWidth-1:0] data_rdata_o,
    output logic                 data_err_o,
    input  logic                 stall_en_i
);

    localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
    localparam int unsigned Depth = 2 ** MemDepthW;

    if (ReadLatency < 1 || ReadLatency > 8) begin : g_bad_latency
        $error("ReadLatency must be in 1..8");
    end
    if (MaxOutstanding < 1 || MaxOutstanding > 8) begin : g_bad_outstanding
        $error("MaxOutstanding must be in 1..8");
    end
    if (BaseAddr[1:0] != 2'b00) begin : g_bad_base
        $error("BaseAddr must be word aligned");
    end
    if (DataWidth != 32 && DataWidth != 33) begin : g_bad_width
        $error("DataWidth must be 32 or 33");
    end

    logic                 stall;
    logic                 hs;
    logic [31:0]          offset;
    logic                 in_range;
    logic [MemDepthW-1:0] idx;
    logic                 req_err;
    logic                 tag_next;
    logic [DataWidth-1:0] rd_word;
    logic [CntW-1:0]      outstanding;

    logic [DataWidth-1:0] mem [Depth];

    logic [ReadLatency-1:0] pipe_valid;
    logic [ReadLatency-1:0] pipe_err;
    logic [DataWidth-1:0]   pipe_data [ReadLatency];

`ifdef DMEM_RESP_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall = stall_en_i && lfsr[0];
`else
    logic unused_stall_en;

    assign unused_stall_en = stall_en_i;
    assign stall           = 1'b0;
`endif

    assign offset   = data_addr_i - BaseAddr;
    assign in_range = (data_addr_i >= BaseAddr) && ((offset >> (MemDepthW + 2)) == 32'd0);
    assign idx      = offset[MemDepthW+1:2];
    assign req_err  = !in_range || (data_addr_i[1:0] != 2'b00) ||
                      (data_is_cap_i && (data_be_i != 4'hF));
    assign tag_next = data_is_cap_i && (data_be_i == 4'hF) && data_wdata_i[DataWidth-1];

    // A response leaving the pipeline this cycle frees its slot immediately.
    assign data_gnt_o = data_req_i && !rst_i && !stall &&
                        ((outstanding < CntW'(MaxOutstanding)) || data_rvalid_o);
    assign hs         = data_req_i && data_gnt_o;

    always_ff @(posedge clk_i) begin
        if (hs && data_we_i && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
            if (DataWidth == 33) begin
                mem[idx][DataWidth-1] <= tag_next;
            end
        end
    end

    assign rd_word = (!data_we_i && !req_err) ? mem[idx] : '0;

    // Idle stages carry zero data so the outputs are clean whenever rvalid is low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            for (int i = 0; i < ReadLatency; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= hs;
            pipe_err[0]   <= hs && req_err;
            pipe_data[0]  <= hs ? rd_word : '0;
            for (int i = 1; i < ReadLatency; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    assign data_rvalid_o = pipe_valid[ReadLatency-1];
    assign data_err_o    = pipe_err[ReadLatency-1];
    assign data_rdata_o  = pipe_data[ReadLatency-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding <= '0;
        end else begin
            case ({hs, data_rvalid_o})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        outstanding <= CntW'(MaxOutstanding));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(data_rvalid_o && !hs && (outstanding == '0)));

endmodule

// File: tb/tb_ibex_dmem_responder.sv
// tb/tb_ibex_dmem_responder.sv - scoreboard bench for ibex_dmem_responder against a word-array model
module tb_ibex_dmem_responder;

    localparam int          L     = 3;
    localparam int          M     = 2;
    localparam int          DEPW  = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h2000_0000;

    typedef struct {
        logic [32:0] data;
        logic        err;
        int          due;
    } resp_t;

    logic        clk;
    logic        rst;
    logic        req;
    logic        is_cap;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [32:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [32:0] rdata;
    logic        err;
    logic        stall_en;

    resp_t       q[$];
    logic [32:0] ref_mem [DEPTH];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    ibex_dmem_responder #(
        .DataWidth(33), .MemDepthW(DEPW), .BaseAddr(BASE),
        .ReadLatency(L), .MaxOutstanding(M)
    ) dut (
        .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_is_cap_i(is_cap),
        .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
        .data_gnt_o(gnt), .data_rvalid_o(rvalid), .data_rdata_o(rdata),
        .data_err_o(err), .stall_en_i(stall_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: actual %h required %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: protocol and response checks against the queue of expected responses.
    bit exp_rvalid;
    bit exp_gnt;
    always @(negedge clk) begin
        if (rst) begin
            check("reset_gnt", 64'(gnt), 64'(0));
            check("reset_rvalid", 64'(rvalid), 64'(0));
            check("reset_rdata", 64'(rdata), 64'(0));
            check("reset_err", 64'(err), 64'(0));
        end else begin
            exp_rvalid = (q.size() > 0) && (q[0].due == cyc);
            exp_gnt    = req && ((q.size() < M) || exp_rvalid);
            check("gnt", 64'(gnt), 64'(exp_gnt));
            check("rvalid", 64'(rvalid), 64'(exp_rvalid));
            if (exp_rvalid) begin
                if (rvalid) begin
                    check("rdata", 64'(rdata), 64'(q[0].data));
                    check("err", 64'(err), 64'(q[0].err));
                end
                void'(q.pop_front());
            end else begin
                check("idle_rdata", 64'(rdata), 64'(0));
                check("idle_err", 64'(err), 64'(0));
            end
        end
    end

    function automatic bit calc_err(input logic [31:0] a, input bit cap, input logic [3:0] b);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off < 0) || ((off / 4) >= DEPTH) || (a[1:0] != 2'b00) || (cap && b != 4'hF);
    endfunction

    task automatic do_op(input logic [31:0] a, input bit w, input logic [3:0] b, input bit cap,
                         input logic [32:0] wd, input int gap);
        int    waited = 0;
        bit    e;
        int    idx;
        resp_t r;
        req = 1'b1; addr = a; we = w; be = b; is_cap = cap; wdata = wd;
        stall_en = 1'($urandom);
        do begin
            @(negedge clk);
            #1;
            waited++;
        end while (!gnt && waited < 40);
        check("grant_wait", 64'(gnt), 64'(1));
        if (gnt) begin
            e   = calc_err(a, cap, b);
            idx = e ? 0 : int'((a - BASE) >> 2);
            if (w && !e) begin
                for (int k = 0; k < 4; k++)
                    if (b[k]) ref_mem[idx][8*k +: 8] = wd[8*k +: 8];
                ref_mem[idx][32] = cap && (b == 4'hF) && wd[32];
            end
            r.data = (!w && !e) ? ref_mem[idx] : 33'd0;
            r.err  = e;
            r.due  = cyc + L;
            q.push_back(r);
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        q.delete();
        req = 1'b1; addr = BASE; we = 1'b0; be = 4'hF; is_cap = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        req = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = int'($urandom_range(0, 9));
        if (k < 8) return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        if (k == 8) return BASE + 32'(4 * $urandom_range(DEPTH, DEPTH + 20));
        if ($urandom_range(0, 1) == 0) return BASE - 32'(4 * $urandom_range(1, 4));
        return BASE + 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
    endfunction

    initial begin
        rst = 1'b1; req = 1'b1; is_cap = 1'b0; we = 1'b0; be = 4'hF;
        addr = BASE; wdata = '0; stall_en = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;

        do_op(BASE, 1'b1, 4'hF, 1'b0, 33'h0_DEADBEEF, 0);
        do_op(BASE, 1'b0, 4'hF, 1'b0, 33'd0, 2);
        for (int i = 1; i < DEPTH; i++)
            do_op(BASE + 32'(4 * i), 1'b1, 4'hF, 1'b0, {1'b1, 32'($urandom)}, 0);

        do_op(BASE + 32'd4, 1'b1, 4'hF, 1'b1, 33'h1_12345678, 0);
        do_op(BASE + 32'd4, 1'b0, 4'hF, 1'b1, 33'd0, 0);
        do_op(BASE + 32'd4, 1'b1, 4'b0001, 1'b0, 33'h0_000000AA, 0);
        do_op(BASE + 32'd4, 1'b0, 4'hF, 1'b0, 33'd0, 4);

        do_op(BASE, 1'b0, 4'hF, 1'b0, 33'd0, 0);
        do_op(BASE + 32'd4, 1'b0, 4'hF, 1'b0, 33'd0, 0);
        do_op(BASE + 32'd8, 1'b0, 4'hF, 1'b0, 33'd0, 4);

        do_op(BASE + 32'(4 * DEPTH), 1'b0, 4'hF, 1'b0, 33'd0, 0);
        do_op(BASE + 32'(4 * DEPTH), 1'b1, 4'hF, 1'b0, 33'h1_FFFFFFFF, 0);
        do_op(BASE + 32'd8, 1'b1, 4'h3, 1'b1, 33'h1_CAFEF00D, 0);
        do_op(BASE + 32'd8, 1'b0, 4'h3, 1'b1, 33'd0, 0);
        do_op(BASE + 32'd8, 1'b0, 4'hF, 1'b0, 33'd0, 0);
        do_op(BASE + 32'd13, 1'b1, 4'hF, 1'b0, 33'h0_11111111, 0);
        do_op(BASE - 32'd4, 1'b0, 4'hF, 1'b0, 33'd0, 0);
        do_op(BASE + 32'd12, 1'b0, 4'hF, 1'b0, 33'd0, 4);

        do_op(BASE, 1'b0, 4'hF, 1'b0, 33'd0, 0);
        do_op(BASE + 32'd4, 1'b0, 4'hF, 1'b0, 33'd0, 0);
        do_reset(2);
        do_op(BASE + 32'd8, 1'b0, 4'hF, 1'b0, 33'd0, 0);
        do_op(BASE + 32'd12, 1'b0, 4'hF, 1'b0, 33'd0, 0);
        do_op(BASE + 32'd16, 1'b0, 4'hF, 1'b0, 33'd0, 3);

        for (int n = 0; n < 300; n++) begin
            logic [3:0] rb;
            bit         rc;
            rc = ($urandom_range(0, 4) == 0);
            rb = (rc && $urandom_range(0, 4) != 0) ? 4'hF : 4'($urandom_range(1, 15));
            do_op(rand_addr(), 1'($urandom), rb, rc, {1'($urandom), 32'($urandom)},
                  int'($urandom_range(0, 2)));
        end

        for (int w = 0; w < 20 && q.size() > 0; w++) @(posedge clk);
        @(negedge clk);
        #1;
        check("drain", 64'(q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
